// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: transfer-size encodings, FSM states and big-endian lane mapping
package arm_mem_pkg;
   typedef enum logic [1:0] {
      DT_BYTE  = 2'b00,
      DT_HALF  = 2'b01,
      DT_WORD  = 2'b10,
      DT_DWORD = 2'b11
   } dt_e;
   typedef enum logic [2:0] {IDLE, WAIT1, BEAT1, WAIT2, HOLD} state_e;
   localparam bit BIG_ENDIAN = 1'b1;
   // index of the last byte lane used by a transfer size (doubleword beats are words)
   function automatic logic [1:0] lane_top(input dt_e dt);
      return (dt == DT_BYTE) ? 2'd0 : (dt == DT_HALF) ? 2'd1 : 2'd3;
   endfunction
   // bit position inside the right-justified data word of byte lane k (lane k = M[A+k])
   function automatic logic [4:0] be_lane_lsb(input dt_e dt, input logic [1:0] k);
      logic [1:0] idx;
      idx = BIG_ENDIAN ? lane_top(dt) - k : k;
      return {idx, 3'b000};
   endfunction
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: 2**ADDR_W x 8 storage, four byte-lane ports, async read, per-lane write enable
module mem_byte_array #(
   parameter int ADDR_W = 8
) (
   input  logic                   clk,
   input  logic [3:0][ADDR_W-1:0] addr_i,
   input  logic [3:0][7:0]        wdata_i,
   input  logic [3:0]             we_i,
   output logic [3:0][7:0]        rdata_o
);
   logic [7:0] mem_q [2**ADDR_W];
   // lanes always hit distinct bytes, so the writes never collide
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) if (we_i[k]) mem_q[addr_i[k]] <= wdata_i[k];
   end
   // asynchronous read of every lane
   always_comb begin
      for (int k = 0; k < 4; k++) rdata_o[k] = mem_q[addr_i[k]];
   end
endmodule

// File: rtl/memory_interface.sv
// memory_interface: big-endian byte RAM with MOV/MOC handshake; MEM_ALIGN_CHECK_EN adds misaligned detection
module memory_interface
   import arm_mem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        MOV,
   input  logic        R_W,
   input  logic [1:0]  DT,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        misaligned,
`endif
   output logic        MOC
);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_W-1:0]      addr_q, addr_d, ea;
   logic                   rw_q, rw_d;
   dt_e                    dt_q, dt_d;
   logic [31:0]            wdata_q, wdata_d, dout_q, dout_d, rd_data;
   logic                   moc_q, moc_d, exec, bad;
   logic [3:0][ADDR_W-1:0] lane_addr;
   logic [3:0][7:0]        lane_wd, lane_rd;
   logic [3:0]             lane_we;
   logic                   addr_hi_unused;
   assign addr_hi_unused = ^address[31:ADDR_W];
`ifdef MEM_ALIGN_CHECK_EN
   assign bad = (dt_q == DT_HALF) ? addr_q[0] : (dt_q != DT_BYTE) && (|addr_q[1:0]);
   assign ea  = addr_q;
   assign misaligned = moc_q & bad;
`else
   assign bad = 1'b0;
   assign ea  = (dt_q == DT_BYTE) ? addr_q :
                (dt_q == DT_HALF) ? {addr_q[ADDR_W-1:1], 1'b0} : {addr_q[ADDR_W-1:2], 2'b00};
`endif
   assign data_out = dout_q;
   assign MOC      = moc_q;
   // state and transfer registers; RAM contents survive reset
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         dt_q    <= DT_BYTE;
         wdata_q <= '0;
         dout_q  <= '0;
         moc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         dt_q    <= dt_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         moc_q   <= moc_d;
      end
   end
   // handshake FSM: accept, count down, execute with MOC, second beat for doublewords, hold until MOV drops
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      dt_d    = dt_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      moc_d   = moc_q;
      exec    = 1'b0;
      case (state_q)
         IDLE: if (MOV) begin
            addr_d  = address[ADDR_W-1:0];
            rw_d    = R_W;
            dt_d    = dt_e'(DT);
            wdata_d = data_in;
            cnt_d   = LAT_M1;
            state_d = WAIT1;
         end
         WAIT1, WAIT2: begin
            if (!MOV) state_d = IDLE;
            else if (cnt_q == '0) begin
               exec    = 1'b1;
               moc_d   = 1'b1;
               dout_d  = rw_q ? (bad ? '0 : rd_data) : dout_q;
               state_d = (state_q == WAIT1 && dt_q == DT_DWORD) ? BEAT1 : HOLD;
            end else cnt_d = cnt_q - 4'd1;
         end
         BEAT1: begin
            moc_d = 1'b0;
            if (!MOV) state_d = IDLE;
            else begin
               addr_d  = addr_q + ADDR_W'(4);
               wdata_d = data_in;
               cnt_d   = LAT_M1;
               state_d = WAIT2;
            end
         end
         HOLD: if (!MOV) begin
            moc_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // lane steering: lane k addresses A+k (wrapping) and maps to its big-endian byte of the data word
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < 4; k++) begin
         lane_addr[k] = ea + ADDR_W'(k);
         lane_wd[k]   = 8'(wdata_q >> be_lane_lsb(dt_q, 2'(k)));
         lane_we[k]   = exec && clr && !rw_q && !bad && (2'(k) <= lane_top(dt_q));
         if (2'(k) <= lane_top(dt_q)) rd_data = rd_data | (32'(lane_rd[k]) << be_lane_lsb(dt_q, 2'(k)));
      end
   end
   mem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
      .clk     (clk),
      .addr_i  (lane_addr),
      .wdata_i (lane_wd),
      .we_i    (lane_we),
      .rdata_o (lane_rd)
   );
endmodule
